writeback_queue: RTL and testbench
==================================

Name: writeback_queue

Overview:
- Writeback buffer that sits directly upstream of the 32x32 integer/float register file.
- Execute and memory stages push completed results into a small FIFO. The FIFO drains one entry per cycle onto the register file write port (writeReg/writeData/regWrite/float).
- Decode uses a combinational scoreboard/forwarding lookup to detect hazards against queued writes and to bypass the youngest pending value.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, minimum 2.
- CW, 3, occupancy counter width; equals log2(DEPTH)+1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- inValid  input  1  producer has a result to write back.
- inReady  output  1  queue can accept an entry this cycle.
- inReg  input  6  destination register index.
- inFloat  input  1  1 = float file, 0 = integer file.
- inData  input  32  result value.
- drainEn  input  1  register file may accept a write this cycle.
- regWrite  output  1  write strobe to register file.
- float  output  1  file select to register file.
- writeReg  output  6  write address to register file.
- writeData  output  32  write data to register file.
- lookupFloat  input  1  file select for both lookups.
- lookupReg1  input  6  first source register queried.
- lookupReg2  input  6  second source register queried.
- hit1  output  1  pending write exists for lookupReg1.
- hit2  output  1  pending write exists for lookupReg2.
- fwdData1  output  32  youngest pending value for lookupReg1; 0 when hit1=0.
- fwdData2  output  32  youngest pending value for lookupReg2; 0 when hit2=0.
- count  output  CW  current FIFO occupancy.
- dropErr  output  1  one-cycle pulse when an accepted entry was discarded.

Behaviour:
- Reset (rst_n=0 at rising edge): FIFO emptied, head/tail pointers 0, count=0, regWrite=0, float=0, writeReg=0, writeData=0, dropErr=0. Reset mid-operation discards all queued entries, including one in flight on the output registers.
- inReady = (count != DEPTH). It is combinational from state only and does not depend on drainEn. A full queue refuses input even in a cycle where it drains.
- Accept: inValid & inReady at an edge.
  - If inReg==0 or inReg[5]==1: entry is consumed but not stored; dropErr=1 next cycle; count unchanged by it.
  - Otherwise {inFloat,inReg,inData} is written at tail and tail advances (wraps modulo DEPTH).
- Drain: at an edge with drainEn=1 and count>0, the head entry loads the output registers, regWrite=1 for the following cycle, and head advances (wraps).
  - If no pop occurs, regWrite=0 next cycle. float, writeReg and writeData hold their last values.
- Latency: an entry accepted at edge N appears with regWrite=1 no earlier than the cycle after edge N+1. There is no input-to-output bypass.
- Simultaneous accept and pop: count unchanged. Pop with no accept: count-1. Accept with no pop: count+1. A dropped accept never changes count.
- Ordering: strict FIFO; writes reach the register file in acceptance order.
- Lookup is purely combinational over valid FIFO entries plus the output stage while regWrite=1.
  - A match requires file select equal AND register index equal. Lookup of register 0 never hits.
  - With multiple matches, fwdData returns the youngest: newest FIFO entry, then older entries, with the output stage oldest.
- Entries being accepted in the current cycle are not visible to lookup until after the edge.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with inValid=1 -> count=0, regWrite=0, inReady=1, hit1=hit2=0 throughout.
- Ordered drain: with drainEn=0, push (int r3,0x11), (float r3,0x22), (int r5,0x33); then drainEn=1 -> regWrite high 3 consecutive cycles with writes in that order; count 3->0; inReady stays 1.
- Full/backpressure: drainEn=0, push 4 entries -> count=4, inReady=0. A 5th inValid is held off. Enable drainEn for one cycle -> count=3; inReady=0 during that edge, 1 after.
- Forwarding: queue int r7=0xA then int r7=0xB. lookupReg1=7, lookupFloat=0 -> hit1=1, fwdData1=0xB. lookupFloat=1 -> hit1=0, fwdData1=0.
- Drop: push inReg=0 then inReg=6'b100001 -> two dropErr pulses, count stays 0, no regWrite.
- Reset mid-run: 3 entries queued with regWrite=1, assert rst_n=0 one edge -> all outputs return to reset values and no further writes occur.

Source files
------------

// File: rtl/writeback_queue.sv
// Writeback buffer in front of the integer/float register file: a small FIFO
// drained one entry per cycle, plus a combinational hazard/forwarding lookup.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inValid,
    output logic          inReady,
    input  logic [5:0]    inReg,
    input  logic          inFloat,
    input  logic [31:0]   inData,
    input  logic          drainEn,
    output logic          regWrite,
    output logic          float,
    output logic [5:0]    writeReg,
    output logic [31:0]   writeData,
    input  logic          lookupFloat,
    input  logic [5:0]    lookupReg1,
    input  logic [5:0]    lookupReg2,
    output logic          hit1,
    output logic          hit2,
    output logic [31:0]   fwdData1,
    output logic [31:0]   fwdData2,
    output logic [CW-1:0] count,
    output logic          dropErr
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        fl;
        logic [5:0]  rg;
        logic [31:0] data;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] idx;

    logic accept;
    logic drop;
    logic push;
    logic pop;

    // Register 0 and indices with bit 5 set have no home in the 32-entry files,
    // so such results are swallowed and flagged rather than queued.
    assign inReady = (count != CW'(DEPTH));
    assign accept  = inValid & inReady;
    assign drop    = accept & ((inReg == 6'd0) | inReg[5]);
    assign push    = accept & ~drop;
    assign pop     = drainEn & (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= '{fl: inFloat, rg: inReg, data: inData};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            regWrite  <= 1'b0;
            float     <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            dropErr   <= 1'b0;
        end else begin
            dropErr  <= drop;
            regWrite <= pop;
            if (pop) begin
                float     <= mem[head].fl;
                writeReg  <= mem[head].rg;
                writeData <= mem[head].data;
                head      <= head + 1'b1;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Scan oldest to youngest (output stage first) so the last match wins.
    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        fwdData1 = '0;
        fwdData2 = '0;
        idx      = head;
        if (regWrite && (float == lookupFloat)) begin
            if ((writeReg == lookupReg1) && (lookupReg1 != 6'd0)) begin
                hit1     = 1'b1;
                fwdData1 = writeData;
            end
            if ((writeReg == lookupReg2) && (lookupReg2 != 6'd0)) begin
                hit2     = 1'b1;
                fwdData2 = writeData;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if ((CW'(i) < count) && (mem[idx].fl == lookupFloat)) begin
                if ((mem[idx].rg == lookupReg1) && (lookupReg1 != 6'd0)) begin
                    hit1     = 1'b1;
                    fwdData1 = mem[idx].data;
                end
                if ((mem[idx].rg == lookupReg2) && (lookupReg2 != 6'd0)) begin
                    hit2     = 1'b1;
                    fwdData2 = mem[idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inValid;
    logic          inReady;
    logic [5:0]    inReg;
    logic          inFloat;
    logic [31:0]   inData;
    logic          drainEn;
    logic          regWrite;
    logic          float;
    logic [5:0]    writeReg;
    logic [31:0]   writeData;
    logic          lookupFloat;
    logic [5:0]    lookupReg1;
    logic [5:0]    lookupReg2;
    logic          hit1;
    logic          hit2;
    logic [31:0]   fwdData1;
    logic [31:0]   fwdData2;
    logic [CW-1:0] count;
    logic          dropErr;

    int testsRun  = 0;
    int testsFail = 0;

    typedef struct {
        logic        fl;
        logic [5:0]  rg;
        logic [31:0] data;
    } entry_t;

    entry_t pending[$];
    entry_t outStage;
    bit     expWrite;
    bit     expDrop;

    writeback_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady), .inReg(inReg), .inFloat(inFloat), .inData(inData),
        .drainEn(drainEn), .regWrite(regWrite), .float(float), .writeReg(writeReg), .writeData(writeData),
        .lookupFloat(lookupFloat), .lookupReg1(lookupReg1), .lookupReg2(lookupReg2),
        .hit1(hit1), .hit2(hit2), .fwdData1(fwdData1), .fwdData2(fwdData2),
        .count(count), .dropErr(dropErr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Youngest pending write wins; the entry already on the write port is oldest.
    function automatic void modelLookup(input logic f, input logic [5:0] r,
                                        output logic hit, output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        if (r != 6'd0) begin
            for (int i = pending.size() - 1; i >= 0; i--) begin
                if (!hit && pending[i].fl == f && pending[i].rg == r) begin
                    hit  = 1'b1;
                    data = pending[i].data;
                end
            end
            if (!hit && expWrite && outStage.fl == f && outStage.rg == r) begin
                hit  = 1'b1;
                data = outStage.data;
            end
        end
    endfunction

    task automatic modelReset();
        pending.delete();
        outStage = '{fl: 1'b0, rg: 6'd0, data: 32'd0};
        expWrite = 1'b0;
        expDrop  = 1'b0;
    endtask

    task automatic modelEdge();
        bit acc;
        if (!rst_n) begin
            modelReset();
        end else begin
            acc     = inValid && (pending.size() < DEPTH);
            expDrop = acc && (inReg == 6'd0 || inReg[5]);
            if (drainEn && pending.size() > 0) begin
                outStage = pending.pop_front();
                expWrite = 1'b1;
            end else begin
                expWrite = 1'b0;
            end
            if (acc && !expDrop) begin
                pending.push_back('{fl: inFloat, rg: inReg, data: inData});
            end
        end
    endtask

    task automatic checkAll();
        logic        h;
        logic [31:0] d;
        checkOutput("inReady", 32'(inReady), 32'(pending.size() != DEPTH));
        checkOutput("count", 32'(count), 32'(pending.size()));
        checkOutput("regWrite", 32'(regWrite), 32'(expWrite));
        checkOutput("float", 32'(float), 32'(outStage.fl));
        checkOutput("writeReg", 32'(writeReg), 32'(outStage.rg));
        checkOutput("writeData", writeData, outStage.data);
        checkOutput("dropErr", 32'(dropErr), 32'(expDrop));
        modelLookup(lookupFloat, lookupReg1, h, d);
        checkOutput("hit1", 32'(hit1), 32'(h));
        checkOutput("fwdData1", fwdData1, d);
        modelLookup(lookupFloat, lookupReg2, h, d);
        checkOutput("hit2", 32'(hit2), 32'(h));
        checkOutput("fwdData2", fwdData2, d);
    endtask

    // Inputs are already driven; check combinational/state outputs, clock once, advance the model.
    task automatic step();
        #2;
        checkAll();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic f, input logic [5:0] r,
                                 input logic [31:0] d, input logic de);
        inValid = v;
        inFloat = f;
        inReg   = r;
        inData  = d;
        drainEn = de;
        step();
    endtask

    initial begin
        rst_n       = 1'b0;
        inValid     = 1'b1;
        inFloat     = 1'b0;
        inReg       = 6'd3;
        inData      = 32'h5;
        drainEn     = 1'b0;
        lookupFloat = 1'b0;
        lookupReg1  = 6'd3;
        lookupReg2  = 6'd0;
        modelReset();

        // First reset edge brings the DUT out of its unknown power-up state.
        @(posedge clk);
        #1;
        applyStimulus(1'b1, 1'b0, 6'd3, 32'h5, 1'b1);
        rst_n = 1'b1;

        // Ordered drain across both files.
        lookupReg1 = 6'd3;
        lookupReg2 = 6'd5;
        applyStimulus(1'b1, 1'b0, 6'd3, 32'h11, 1'b0);
        applyStimulus(1'b1, 1'b1, 6'd3, 32'h22, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd5, 32'h33, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 6'd0, 32'h0, 1'b1);

        // Fill to capacity, hold a fifth request off, then drain one.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 6'(8 + i), 32'(100 + i), 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd12, 32'd104, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd12, 32'd104, 1'b1);
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1);

        // Forwarding picks the younger of two writes to the same register.
        applyStimulus(1'b1, 1'b0, 6'd7, 32'hA, 1'b0);
        applyStimulus(1'b1, 1'b0, 6'd7, 32'hB, 1'b0);
        inValid     = 1'b0;
        lookupReg1  = 6'd7;
        lookupReg2  = 6'd0;
        lookupFloat = 1'b0;
        #2;
        checkOutput("fwdYoungest", fwdData1, 32'hB);
        step();
        lookupFloat = 1'b1;
        #2;
        checkOutput("fwdOtherFile", fwdData1, 32'h0);
        step();
        lookupFloat = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1);

        // Illegal destinations are swallowed with an error pulse.
        applyStimulus(1'b1, 1'b0, 6'd0, 32'hDEAD, 1'b1);
        applyStimulus(1'b1, 1'b0, 6'b100001, 32'hBEEF, 1'b1);
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1);

        // Reset while draining discards everything, including the output stage.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 6'(20 + i), 32'(500 + i), 1'b0);
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
        lookupReg1  = 6'd22;
        lookupFloat = 1'b1;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 6'd0, 32'd0, 1'b1);

        // Random traffic over a small register range to provoke hazards.
        for (int n = 0; n < 2000; n++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            lookupFloat = 1'($urandom_range(0, 1));
            lookupReg1  = 6'($urandom_range(0, 7));
            lookupReg2  = 6'($urandom_range(0, 7));
            applyStimulus(1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          {1'($urandom_range(0, 9) == 0), 5'($urandom_range(0, 7))},
                          $urandom,
                          1'($urandom_range(0, 2) != 0));
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
